ssd_key_entry_mux: RTL and testbench
====================================

# ssd_key_entry_mux

Two-digit key-entry buffer and display multiplexer for the PmodSSD. It sits directly downstream of `keypad_decoder`, consuming `decode_out` / `is_a_key_pressed`. Each new key press is captured into a left/right digit pair, filling left first and then right. The block time-multiplexes both digits onto the shared `seg` bus with a free-running `chip_sel` refresh toggle.

## Interface
- `clk_freq`, default 125_000_000: system clock frequency in Hz.
- `refresh_hz`, default 100: full two-digit refresh rate in Hz. Each digit is driven for `DIGIT_CYCLES = clk_freq / (2*refresh_hz)` cycles; 625_000 at the defaults. Requires `DIGIT_CYCLES >= 2`.
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high; clears all state.
- `key_code`, input, 4: hex code of the current key, from `decode_out`. Valid while `key_pressed` is 1.
- `key_pressed`, input, 1: level indicating a key is held, from `is_a_key_pressed`. Synchronous to `clk`.
- `clear`, input, 1: single-cycle pulse that empties both digits.
- `seg`, output, 7: segment drive, active-high, ordered `{a,b,c,d,e,f,g}` (`seg[6]` = a). Examples: "0" = 7'b1111110, "2" = 7'b1101101.
- `chip_sel`, output, 1: digit select. 1 = left digit driven, 0 = right digit driven.
- `left_digit`, output, 4: captured left value.
- `right_digit`, output, 4: captured right value.
- `digit_count`, output, 2: number of valid digits, 0..2.

## Operation
- **Press detection:** `key_pressed` is registered once internally (`kp_q`). A press event is the cycle where `key_pressed`=1 and `kp_q`=0. `key_code` is sampled in that same cycle. A key that is held generates exactly one event.
- **Entry FSM states:**
  - EMPTY (count 0): a press loads `left_digit`=code and moves to ONE.
  - ONE (count 1): a press loads `right_digit`=code and moves to TWO.
  - TWO (count 2): a press starts a new entry. It loads `left_digit`=code, sets `right_digit`=0, and moves to ONE.
- **Clear:** `clear`=1 in any state forces EMPTY and sets both digits to 0. Clear has priority over a press event in the same cycle; that press is dropped.
- **Refresh counter:** counts 0..`DIGIT_CYCLES`-1. On the terminal count it wraps to 0 and `chip_sel` toggles. It runs regardless of FSM state or key activity.
- **Segment source:** `seg` is the 7-segment decode of `left_digit` when `chip_sel`=1 and of `right_digit` when `chip_sel`=0. A digit that is not valid (left when count=0; right when count<2) is shown per the Configuration section.
- **Hex decode:** covers 0-9 and A-F, with lowercase b and d.

## Timing
- **Reset values:** `seg`=7'b0000000, `chip_sel`=0, `left_digit`=0, `right_digit`=0, `digit_count`=0, refresh counter=0, `kp_q`=0, FSM=EMPTY.
- **Registered outputs:** `seg` and `chip_sel` are registered and update on the same edge. `seg` is always computed from the next `chip_sel` value and the current digit registers.
- **Capture latency:** for a press event sampled at edge N, `left_digit`/`right_digit`/`digit_count` update at edge N. `seg` reflects the new digit at edge N+1, if that digit is selected.
- **Clear latency:** `clear` sampled at edge N; digits and `digit_count` read 0 after edge N.
- **Refresh period:** `chip_sel` holds each value for exactly `DIGIT_CYCLES` cycles. The first toggle comes `DIGIT_CYCLES` cycles after reset deassertion.
- **Reset mid-operation:** asynchronous reset returns everything to the reset values immediately. A key still held when reset deasserts generates one event on the first cycle that `key_pressed`=1 and `kp_q`=0. Because `kp_q` resets to 0, a key held through reset is captured once.
- **Fast presses:** back-to-back events separated by one cycle of `key_pressed`=0 are each captured.

## Configuration
- Macro: `SSD_BLANK_EN`.
- **Defined:** an invalid digit drives `seg`=7'b0000000 (blank).
- **Undefined:** an invalid digit displays its stored value. That value is 0 after reset or clear, so it shows "0" (7'b1111110).
- Capture, FSM and refresh behaviour are identical in both builds.

## Test plan
All scenarios use `clk_freq`=1000, `refresh_hz`=100, so `DIGIT_CYCLES`=5.
- **Reset/refresh:** assert `rst` mid-run → all outputs 0 immediately. After release, `chip_sel` toggles every 5 cycles: 0,0,0,0,0,1,1,1,1,1,0…
- **Two-digit entry:** press code 4, release, press code 9 → `left_digit`=4, `right_digit`=9, `digit_count`=2. `seg` alternates 7'b0110011 (chip_sel=1) and 7'b1111011 (chip_sel=0).
- **Third press and hold:** with 4/9 loaded, hold code A for 20 cycles → one event only. Result: `left_digit`=A, `right_digit`=0, `digit_count`=1. The right digit is blank with `SSD_BLANK_EN`, and shows 7'b1111110 without it.
- **Clear priority:** assert `clear` in the same cycle as a press of code 7 → `digit_count`=0, both digits 0, and 7 is not captured.
- **Reset with key held:** hold code 3 across reset release → exactly one capture, `left_digit`=3, `digit_count`=1.
- **Full hex sweep:** enter codes 0-F pairwise → `seg` matches the decode table for all 16 codes on both digits.

Source files
------------

// File: rtl/ssd_key_entry_mux.sv
// ssd_key_entry_mux -- two-digit key-entry buffer and PmodSSD display mux.
//
// Sits behind keypad_decoder. Each rising edge of key_pressed captures
// key_code into the left digit, then the right digit; a third press starts
// a fresh entry (left=code, right=0). Both digits are time-multiplexed onto
// the shared seg bus with a free-running chip_sel toggle.
//
// Parameters:
//   clk_freq    system clock in Hz
//   refresh_hz  full two-digit refresh rate in Hz
//               DIGIT_CYCLES = clk_freq/(2*refresh_hz), must be >= 2
// Ports:
//   clk, rst              clock, async active-high reset
//   key_code[3:0]         hex code, valid while key_pressed
//   key_pressed           key held level (synchronous to clk)
//   clear                 one-cycle pulse, empties both digits
//   seg[6:0]              {a,b,c,d,e,f,g}, active-high, registered
//   chip_sel              1 = left digit driven, 0 = right, registered
//   left_digit[3:0]       captured left value
//   right_digit[3:0]      captured right value
//   digit_count[1:0]      number of valid digits (0..2)
// Build option:
//   SSD_BLANK_EN          defined: invalid digits are blanked;
//                         undefined: invalid digits show their stored 0

// Hex to 7-segment, {a..g}, lowercase b and d.
module ssd_hex_dec (
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0000000;
    case (code)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

module ssd_key_entry_mux #(
  parameter int clk_freq   = 125_000_000,
  parameter int refresh_hz = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_pressed,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       chip_sel,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit,
  output logic [1:0] digit_count
);
  localparam int DIGIT_CYCLES = clk_freq / (2 * refresh_hz);
  localparam int CW           = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int NUM_DIGITS   = 2;

  // FSM encoding doubles as the valid-digit count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]    state;
  logic          kp_q;
  logic [CW-1:0] ref_cnt;
  logic          press_evt;
  logic          ref_tc;
  logic          sel_next;
  logic [6:0]    seg_next;

  // Index 1 = left digit, 0 = right digit, so chip_sel indexes directly.
  logic [NUM_DIGITS-1:0][3:0] dval;
  logic [NUM_DIGITS-1:0][6:0] dseg;

  assign press_evt   = key_pressed & ~kp_q;
  assign ref_tc      = (ref_cnt == CW'(DIGIT_CYCLES - 1));
  assign sel_next    = ref_tc ? ~chip_sel : chip_sel;
  assign digit_count = state;
  assign dval        = {left_digit, right_digit};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    ssd_hex_dec u_dec (
      .code (dval[g]),
      .seg  (dseg[g])
    );
  end

  // seg uses the post-edge chip_sel but the pre-edge digits, so a fresh
  // capture appears on seg one edge after the digit register changes.
`ifdef SSD_BLANK_EN
  logic [NUM_DIGITS-1:0] dvalid;
  assign dvalid[1] = (state != S_EMPTY);
  assign dvalid[0] = (state == S_TWO);
  assign seg_next  = dvalid[sel_next] ? dseg[sel_next] : 7'b0000000;
`else
  assign seg_next  = dseg[sel_next];
`endif

  // Press edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) kp_q <= 1'b0;
    else     kp_q <= key_pressed;
  end

  // Refresh divider and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      chip_sel <= 1'b0;
      seg      <= 7'b0000000;
    end else begin
      ref_cnt  <= ref_tc ? '0 : ref_cnt + 1'b1;
      chip_sel <= sel_next;
      seg      <= seg_next;
    end
  end

  // Entry FSM; clear wins over a same-cycle press, which is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      left_digit  <= 4'h0;
      right_digit <= 4'h0;
    end else if (clear) begin
      state       <= S_EMPTY;
      left_digit  <= 4'h0;
      right_digit <= 4'h0;
    end else if (press_evt) begin
      case (state)
        S_ONE: begin
          right_digit <= key_code;
          state       <= S_TWO;
        end
        S_TWO: begin
          left_digit  <= key_code;
          right_digit <= 4'h0;
          state       <= S_ONE;
        end
        default: begin
          left_digit <= key_code;
          state      <= S_ONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ssd_key_entry_mux.sv
module tb_ssd_key_entry_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_pressed = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic       chip_sel;
  logic [3:0] left_digit, right_digit;
  logic [1:0] digit_count;

  ssd_key_entry_mux #(.clk_freq(1000), .refresh_hz(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .clear       (clear),
    .seg         (seg),
    .chip_sel    (chip_sel),
    .left_digit  (left_digit),
    .right_digit (right_digit),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

`ifdef SSD_BLANK_EN
  localparam logic [6:0] INV = 7'b0000000;
`else
  localparam logic [6:0] INV = 7'b1111110;
`endif

  // Reference model of the digit registers.
  logic [3:0] m_left = 4'h0;
  logic [3:0] m_right = 4'h0;
  int         m_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h required nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic push_digits(input string t);
    push({t, "_left"},  16'(m_left));
    push({t, "_right"}, 16'(m_right));
    push({t, "_count"}, 16'(m_cnt));
  endtask

  task automatic check_digits;
    check(16'(left_digit));
    check(16'(right_digit));
    check(16'(digit_count));
  endtask

  task automatic check_all_zero(input string t);
    push({t, "_seg"},      16'h0);
    push({t, "_chip_sel"}, 16'h0);
    push({t, "_left"},     16'h0);
    push({t, "_right"},    16'h0);
    push({t, "_count"},    16'h0);
    check(16'(seg));
    check(16'(chip_sel));
    check_digits();
  endtask

  // Press a key for `hold` cycles, then release for one cycle.
  task automatic press(input logic [3:0] code, input int hold);
    string t;
    t = $sformatf("press_%h", code);
    case (m_cnt)
      0: begin m_left = code; m_cnt = 1; end
      1: begin m_right = code; m_cnt = 2; end
      default: begin m_left = code; m_right = 4'h0; m_cnt = 1; end
    endcase
    push_digits(t);
    key_code    = code;
    key_pressed = 1'b1;
    tick();
    check_digits();
    repeat (hold - 1) tick();
    key_pressed = 1'b0;
    tick();
    push_digits({t, "_after_release"});
    check_digits();
  endtask

  // Wait (bounded) until chip_sel shows `side`, then compare seg.
  task automatic show(input logic side, input logic [6:0] e, input string t);
    int n;
    push(t, 16'(e));
    tick();
    n = 0;
    while (chip_sel !== side && n < 20) begin
      tick();
      n++;
    end
    if (chip_sel !== side) begin
      void'(exp_q.pop_front());
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout: observed chip_sel %0b required %0b", t, chip_sel, side);
    end else begin
      check(16'(seg));
    end
  endtask

  function automatic logic [6:0] exp_left();
    return (m_cnt != 0) ? tbl[m_left] : INV;
  endfunction

  function automatic logic [6:0] exp_right();
    return (m_cnt == 2) ? tbl[m_right] : INV;
  endfunction

  initial begin
    // Reset state.
    repeat (2) tick();
    check_all_zero("reset");

    // Refresh cadence from reset release.
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("refresh_sel_%0d", k), 16'((k / 5) % 2));
      push($sformatf("refresh_seg_%0d", k), 16'(INV));
      tick();
      check(16'(chip_sel));
      check(16'(seg));
    end

    // Two-digit entry with a one-cycle gap between presses.
    press(4'h4, 1);
    show(1'b0, exp_right(), "one_digit_right");
    show(1'b1, exp_left(),  "one_digit_left");
    press(4'h9, 1);
    show(1'b1, tbl[4], "two_digit_left");
    show(1'b0, tbl[9], "two_digit_right");

    // Third press held for 20 cycles: one event only.
    press(4'hA, 20);
    show(1'b0, exp_right(), "third_right");
    show(1'b1, exp_left(),  "third_left");

    // Clear beats a same-cycle press; the held key produces no later event.
    m_left = 4'h0; m_right = 4'h0; m_cnt = 0;
    push_digits("clear_prio");
    key_code    = 4'h7;
    key_pressed = 1'b1;
    clear       = 1'b1;
    tick();
    clear = 1'b0;
    check_digits();
    tick();
    key_pressed = 1'b0;
    tick();
    push_digits("clear_prio_held");
    check_digits();
    show(1'b1, INV, "clear_left");

    // Mid-run asynchronous reset with a key held across release.
    press(4'h2, 1);
    key_code    = 4'h3;
    key_pressed = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    m_left = 4'h3; m_right = 4'h0; m_cnt = 1;
    push_digits("held_thru_reset");
    tick();
    check_digits();
    repeat (4) tick();
    key_pressed = 1'b0;
    tick();
    push_digits("held_thru_reset_after");
    check_digits();

    // Full hex sweep on both digits.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_left = 4'h0; m_right = 4'h0; m_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      press(4'(2 * p), 1);
      press(4'(2 * p + 1), 1);
      show(1'b1, tbl[2 * p],     $sformatf("sweep_left_%h", 2 * p));
      show(1'b0, tbl[2 * p + 1], $sformatf("sweep_right_%h", 2 * p + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
